// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and helpers for the iterative multiply/divide
//             sequencer (operation codes, FSM states, opcode decode).
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   // Operation codes as presented by EX
   typedef enum logic [1:0] {
      MULTU = 2'b00,
      MULT  = 2'b01,
      DIVU  = 2'b10,
      DIV   = 2'b11
   } md_op_t;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } md_state_t;

   // Signed variants carry a 1 in bit 0
   function automatic logic is_signed(input md_op_t op);
      return op[0];
   endfunction

   // Divide variants carry a 1 in bit 1
   function automatic logic is_div(input md_op_t op);
      return op[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative radix-2 multiply / restoring divide sequencer that
//             owns the HI/LO pair, services MTHI/MTLO and raises a pipeline
//             stall while a result is outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hilo_rd,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] c_count_init = CW'(WIDTH);
   localparam logic [CW-1:0] c_count_last = CW'(1);

   md_state_t          r_state;
   md_state_t          w_state_nxt;
   logic [CW-1:0]      r_count;
   // r_acc: product high / partial remainder (raw dividend on divide-by-zero)
   // r_low: multiplier being consumed / quotient being built
   // r_opnd: multiplicand magnitude / divisor magnitude
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_low;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_div;
   logic               r_dbz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_accept;
   logic               w_op_signed;
   logic               w_op_div;
   logic               w_b_zero;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH-1:0]   w_sub;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quo_s;
   logic [WIDTH-1:0]   w_rem_s;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   // Operation request decode and operand magnitudes (negation wraps at WIDTH)
   always_comb begin
      w_accept    = start & ~flush;
      w_op_signed = is_signed(op);
      w_op_div    = is_div(op);
      w_b_zero    = (b == '0);
      w_mag_a     = (w_op_signed & a[WIDTH-1]) ? -a : a;
      w_mag_b     = (w_op_signed & b[WIDTH-1]) ? -b : b;
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      w_add    = r_low[0] ? ({1'b0, r_acc} + {1'b0, r_opnd}) : {1'b0, r_acc};
      w_rem_sh = {r_acc, r_low[WIDTH-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_opnd});
      // When w_ge holds the true difference is below 2^WIDTH, so a modular
      // WIDTH-bit subtract is exact.
      w_sub    = w_rem_sh[WIDTH-1:0] - r_opnd;
   end

   // Sign fix-up and result selection for the FIX cycle
   always_comb begin
      w_prod_s = r_neg_res ? -{r_acc, r_low} : {r_acc, r_low};
      w_quo_s  = r_neg_res ? -r_low : r_low;
      w_rem_s  = r_neg_rem ? -r_acc : r_acc;
      if (r_dbz) begin
         w_fix_hi = r_acc;
         w_fix_lo = '1;
      end else if (r_div) begin
         w_fix_hi = w_rem_s;
         w_fix_lo = w_quo_s;
      end else begin
         w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
         w_fix_lo = w_prod_s[WIDTH-1:0];
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = (w_op_div & w_b_zero) ? FIX : RUN;
            end
         end
         RUN: begin
            if (flush) begin
               w_state_nxt = IDLE;
            end else if (r_count == c_count_last) begin
               w_state_nxt = FIX;
            end
         end
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Work registers: operand latch on accept, one iteration per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count   <= '0;
         r_acc     <= '0;
         r_low     <= '0;
         r_opnd    <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div     <= 1'b0;
         r_dbz     <= 1'b0;
      end else if (r_state == IDLE) begin
         if (w_accept) begin
            r_count   <= c_count_init;
            r_div     <= w_op_div;
            r_dbz     <= w_op_div & w_b_zero;
            r_neg_res <= w_op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= w_op_signed & a[WIDTH-1];
            if (w_op_div & w_b_zero) begin
               r_acc  <= a;
               r_low  <= '0;
               r_opnd <= '0;
            end else if (w_op_div) begin
               r_acc  <= '0;
               r_low  <= w_mag_a;
               r_opnd <= w_mag_b;
            end else begin
               r_acc  <= '0;
               r_low  <= w_mag_b;
               r_opnd <= w_mag_a;
            end
         end
      end else if (r_state == RUN && !flush) begin
         r_count <= r_count - 1'b1;
         if (r_div) begin
            r_acc <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
            r_low <= {r_low[WIDTH-2:0], w_ge};
         end else begin
            r_acc <= w_add[WIDTH:1];
            r_low <= {w_add[0], r_low[WIDTH-1:1]};
         end
      end
   end

   // HI/LO: MTHI/MTLO while idle, operation result on an unflushed FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == FIX) & ~flush;
         if (r_state == IDLE) begin
            if (wr_hi) r_hi <= wd;
            if (wr_lo) r_lo <= wd;
         end else if (r_state == FIX && !flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end

   assign busy  = (r_state != IDLE);
   assign done  = r_done;
   assign stall = busy & (start | hilo_rd | wr_hi | wr_lo);
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Directed self-checking bench for muldiv_seq with a result
//             scoreboard filled at start and drained at done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             start;
   md_op_t           op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             hilo_rd;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int               tests_run;
   int               tests_failed;
   logic [63:0]      sb_q[$];
   logic [31:0]      model_hi;
   logic [31:0]      model_lo;

   muldiv_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo),
      .wd(wd), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: {hi, lo} for a completed operation
   function automatic logic [63:0] model(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         MULTU:   p = {32'h0, x} * {32'h0, y};
         MULT:    p = 64'(sx * sy);
         DIVU:    p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         default: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   // Waits for done starting at cycle first_n, checking latency and result
   task automatic wait_done(input int lat, input int first_n);
      logic        got;
      logic        busy_ok;
      logic [63:0] exp;
      got     = 1'b0;
      busy_ok = 1'b1;
      for (int n = first_n; n <= 100 && !got; n++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (done) begin
            got = 1'b1;
            check("latency", 64'(n), 64'(lat));
            exp = sb_q.pop_front();
            check("hi", {32'h0, hi}, {32'h0, exp[63:32]});
            check("lo", {32'h0, lo}, {32'h0, exp[31:0]});
            check("busy_in_done", {63'h0, busy}, 64'h0);
            model_hi = exp[63:32];
            model_lo = exp[31:0];
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
      check("done_seen", {63'h0, got}, 64'h1);
      check("busy_window", {63'h0, busy_ok}, 64'h1);
   endtask

   task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
      sb_q.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
   endtask

   task automatic run_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
      issue(o, x, y);
      wait_done((o[1] && y == 0) ? 2 : 34, 1);
   endtask

   initial begin
      logic        flag;
      logic        lo_bad;
      logic [63:0] exp;
      logic [31:0] ra;
      logic [31:0] rb;
      tests_run    = 0;
      tests_failed = 0;
      model_hi     = '0;
      model_lo     = '0;
      rst = 1'b0; start = 1'b0; op = MULTU; a = '0; b = '0; flush = 1'b0;
      hilo_rd = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;

      // Reset state
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_hi",    {32'h0, hi}, 64'h0);
      check("rst_lo",    {32'h0, lo}, 64'h0);
      check("rst_busy",  {63'h0, busy}, 64'h0);
      check("rst_done",  {63'h0, done}, 64'h0);
      check("rst_stall", {63'h0, stall}, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed arithmetic cases
      run_op(MULTU, 32'hFFFF_FFFF, 32'd2);
      run_op(MULT,  32'hFFFF_FFFD, 32'd5);
      run_op(MULT,  32'h8000_0000, 32'h8000_0000);
      run_op(DIV,   32'hFFFF_FFF9, 32'd2);
      run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(DIVU,  32'd7, 32'd0);
      run_op(DIV,   32'hFFFF_FFF9, 32'd0);
      run_op(DIVU,  32'd100, 32'd7);

      // Random operations against the model
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(md_op_t'(i % 4), ra, rb);
      end

      // MTHI preload, then flush an in-flight MULTU at cycle 10
      @(negedge clk);
      wr_hi = 1'b1; wd = 32'h0000_AAAA;
      @(negedge clk);
      wr_hi = 1'b0;
      #1;
      check("mthi", {32'h0, hi}, 64'h0000_AAAA);
      model_hi = 32'h0000_AAAA;
      @(negedge clk);
      start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (n == 10);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy", {63'h0, busy}, 64'h0);
      flag = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         if (done) flag = 1'b1;
      end
      check("flush_no_done", {63'h0, flag}, 64'h0);
      check("flush_hi", {32'h0, hi}, {32'h0, model_hi});
      check("flush_lo", {32'h0, lo}, {32'h0, model_lo});

      // hilo_rd from cycle 5 stalls through cycle 33; MTLO in cycle 6 ignored
      sb_q.push_back(model(MULTU, 32'd5, 32'd6));
      @(negedge clk);
      start = 1'b1; op = MULTU; a = 32'd5; b = 32'd6;
      flag   = 1'b0;
      lo_bad = 1'b0;
      for (int n = 1; n <= 34; n++) begin
         @(negedge clk);
         start   = 1'b0;
         hilo_rd = (n >= 5);
         wr_lo   = (n == 6);
         wd      = 32'hDEAD_BEEF;
         #1;
         if (n <= 4 && stall) flag = 1'b1;
         if (n >= 5 && n <= 33 && !stall) flag = 1'b1;
         if (n <= 33 && lo !== model_lo) lo_bad = 1'b1;
         if (n == 34) begin
            check("stall_done_cycle", {63'h0, stall}, 64'h0);
            check("stall_done", {63'h0, done}, 64'h1);
            exp = sb_q.pop_front();
            check("stall_lo", {32'h0, lo}, {32'h0, exp[31:0]});
            check("stall_hi", {32'h0, hi}, {32'h0, exp[63:32]});
            model_hi = exp[63:32];
            model_lo = exp[31:0];
         end
      end
      check("stall_window", {63'h0, flag}, 64'h0);
      check("mtlo_busy_ignored", {63'h0, lo_bad}, 64'h0);
      @(negedge clk);
      hilo_rd = 1'b0; wr_lo = 1'b0;

      // start while busy neither stalls silently nor re-latches operands
      issue(MULTU, 32'd7, 32'd9);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a = 32'h0000_FFFF; b = 32'h0000_FFFF;
      #1;
      check("stall_on_start", {63'h0, stall}, 64'h1);
      wait_done(34, 4);
      @(negedge clk);
      #1;
      check("no_restart", {63'h0, busy}, 64'h0);

      // MTLO together with start in IDLE: write lands, then result overwrites
      issue(DIVU, 32'd100, 32'd7);
      wr_lo = 1'b1; wd = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0; wr_lo = 1'b0;
      #1;
      check("mtlo_with_start", {32'h0, lo}, 64'h1234_5678);
      check("busy_after_start", {63'h0, busy}, 64'h1);
      wait_done(34, 2);

      // flush together with start in IDLE drops the start
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_drops_start", {63'h0, busy}, 64'h0);

      // Asynchronous reset in cycle 20 of an operation
      @(negedge clk);
      start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
      for (int n = 1; n < 20; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      hilo_rd = 1'b1;
      rst     = 1'b1;
      #1;
      check("arst_hi",    {32'h0, hi}, 64'h0);
      check("arst_lo",    {32'h0, lo}, 64'h0);
      check("arst_busy",  {63'h0, busy}, 64'h0);
      check("arst_done",  {63'h0, done}, 64'h0);
      check("arst_stall", {63'h0, stall}, 64'h0);
      @(negedge clk);
      rst = 1'b0; hilo_rd = 1'b0;
      model_hi = '0;
      model_lo = '0;

      // Operation after reset still works
      run_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      check("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair.
- Replaces the single-cycle combinational multiplier feeding HI/LO in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU from EX, runs a radix-2 shift-add / restoring-divide loop, writes HI/LO, and raises a stall to the hazard logic while a result is outstanding.
- Also services MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  operation request from EX; sampled only when busy=0
op  in  2  muldiv_pkg::md_op_t: MULTU=00, MULT=01, DIVU=10, DIV=11
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
flush  in  1  abort the in-flight operation (branch mispredict / pipeline flush)
hilo_rd  in  1  MFHI/MFLO in EX needs HI/LO this cycle
wr_hi  in  1  MTHI write strobe
wr_lo  in  1  MTLO write strobe
wd  in  WIDTH  MTHI/MTLO write data
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO just updated by an operation
stall  out  1  freeze F/D/E stages
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0, stall=0; counter and work registers cleared.
- States are IDLE, RUN and FIX.
- IDLE → RUN: start=1 and flush=0. On that edge:
  - latch operand magnitudes; for signed ops take |a| and |b|;
  - latch sign flags neg_res = a[MSB]^b[MSB] and neg_rem = a[MSB], both forced to 0 for unsigned ops;
  - load count=WIDTH.
- IDLE → FIX (division by zero): op is DIV/DIVU and b=0. Go straight to FIX; result is lo=all-ones, hi=a (raw a, unchanged).
- RUN: one iteration per cycle; count decrements.
  - Multiply: {acc,mplr} shift-add, WIDTH+1-bit adder.
  - Divide: restoring; {rem,quo} shifts left and subtracts the divisor if rem≥divisor.
  - When count reaches 1, go to FIX on the next edge.
- FIX, one cycle:
  - apply sign: the 2WIDTH-bit product is negated if neg_res; the quotient is negated if neg_res; the remainder is negated if neg_rem;
  - write hi (product high / remainder) and lo (product low / quotient);
  - go to IDLE.
- DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0 (natural magnitude result, no special case).
- busy = (state != IDLE), registered.
- done = 1 in the cycle after FIX only.
- Latency: start sampled in cycle 0; busy=1 in cycles 1..WIDTH+1; hi/lo valid and done=1 in cycle WIDTH+2 (34 for WIDTH=32). For divide-by-zero, done is in cycle 2.
- stall = busy & (start | hilo_rd | wr_hi | wr_lo), combinational. No stall is raised in the done cycle.
- MTHI/MTLO: wr_hi/wr_lo update hi/lo on the edge when busy=0 and are ignored while busy (stall holds them).
  - If start and wr_hi/wr_lo arrive in the same IDLE cycle, the write happens and the operation also starts; the operation result overwrites later.
- flush:
  - In RUN or FIX: return to IDLE on the next edge; hi/lo are unchanged, done is not pulsed, busy=0 in the next cycle.
  - In IDLE: flush with start means the start is dropped.
  - flush does not block wr_hi/wr_lo.
- start while busy: ignored (never re-latches operands).
- Reset mid-operation: immediate return to the reset values above.
- Width rules:
  - count is $clog2(WIDTH)+1 bits;
  - the abs/negate logic operates on WIDTH bits and wraps (|0x80000000| = 0x80000000 treated as unsigned).

Decomposition:
- muldiv_pkg:
  - md_op_t enum (MULTU, MULT, DIVU, DIV);
  - md_state_t enum (IDLE, RUN, FIX);
  - helper function is_signed(op);
  - helper function is_div(op).
- No sub-module; the adder/subtractor stays inline. The existing mult instance and the lo/hi dreg instances are removed from the datapath, and hi/lo come from this block.

Test Plan:
- MULTU a=0xFFFFFFFF b=2, start cycle 0 → busy cycles 1–33; cycle 34: done=1, hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3 b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT a=0x80000000 b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7 b=0 → done in cycle 2, lo=0xFFFFFFFF, hi=7.
- Preload hi=0xAAAA via wr_hi; start MULTU 3×3; flush in cycle 10 → busy=0 in cycle 11, no done pulse, hi=0xAAAA, lo unchanged.
- hilo_rd=1 held from cycle 5 during MULTU → stall=1 in cycles 5–33 and 0 in cycle 34.
- wr_lo in cycle 6 is ignored.
- Assert rst in cycle 20 → all outputs 0 immediately.
